seg_scan_arbiter: RTL and testbench

Display controller for the board's 8-digit multiplexed 7-segment display. Holds an 8-digit hex frame buffer and shares write access to it between two requesters (CPU-side debug port and switch/LED monitor) through a valid/ready handshake with round-robin arbitration. Time-multiplexes the digits onto the shared `an`/`a2g` pins with a programmable dwell prescaler. Sits between the core's debug outputs and the top-level board pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_arbiter_if.sv | 21 ++
 rtl/hex7seg.sv | 11 +
 rtl/seg_scan_arbiter.sv | 96 +++++++++
 tb/tb_seg_scan_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 8-digit seven-segment display path.
package seg_pkg;

  localparam int         NDIGIT    = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef struct packed {
    logic       lit;
    logic [3:0] nib;
  } digit_t;

  // Active-low g..a codes indexed by nibble value; the first element listed is index 15.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// Two-requester write port into the display frame buffer (valid/ready per requester).
interface seg_scan_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic [7:0]  req0_wen;
  logic [7:0]  req1_wen;

  modport master (
    output req_valid, req0_data, req1_data, req0_wen, req1_wen,
    input  req_ready
  );

  modport slave (
    input  req_valid, req0_data, req1_data, req0_wen, req1_wen,
    output req_ready
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment (g..a) decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_arbiter.sv
// 8-digit hex display controller: round-robin write arbiter, frame buffer,
// dwell prescaler with digit scan, and registered anode/segment outputs.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int DIV_W = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_en,
  seg_scan_arbiter_if.slave   req,
  output logic [7:0]          an,
  output logic [6:0]          a2g
);

  logic                    last_q, last_d;
  digit_t [NDIGIT-1:0]     fb_q, fb_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              an_q, an_d;
  logic [6:0]              a2g_q, a2g_d;

  logic [1:0]              grant;
  logic                    xfer;
  logic                    win;
  logic [31:0]             wdata;
  logic [7:0]              wen;
  digit_t                  cur;
  logic [6:0]              cur_seg;

  // last_q == 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    grant = 2'b00;
    case (req.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req.req_ready = grant;
  assign xfer          = |(req.req_valid & grant);
  assign win           = grant[1];
  assign wdata         = win ? req.req1_data : req.req0_data;
  assign wen           = win ? req.req1_wen  : req.req0_wen;

  always_comb begin
    fb_d   = fb_q;
    last_d = last_q;
    if (xfer) begin
      last_d = win;
      for (int k = 0; k < NDIGIT; k++) begin
        if (wen[k]) begin
          fb_d[k].lit = 1'b1;
          fb_d[k].nib = wdata[4*k +: 4];
        end
      end
    end
  end

  assign div_d = div_q + DIV_W'(1);
  assign idx_d = (div_q == '1) ? idx_q + 3'd1 : idx_q;

  assign cur = fb_q[idx_q];

  hex7seg u_hex7seg (
    .nib_i (cur.nib),
    .seg_o (cur_seg)
  );

  assign an_d  = disp_en ? ~(8'b1 << idx_q) : AN_OFF;
  assign a2g_d = cur.lit ? cur_seg : SEG_BLANK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
      fb_q   <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= AN_OFF;
      a2g_q  <= SEG_BLANK;
    end else begin
      last_q <= last_d;
      fb_q   <= fb_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      a2g_q  <= a2g_d;
    end
  end

  assign an  = an_q;
  assign a2g = a2g_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter with a short dwell (DIV_W=2, 4 cycles per digit).
`timescale 1ns/1ps
module tb_seg_scan_arbiter;
  import seg_pkg::*;

  localparam int DIV_W = 2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       disp_en = 1'b1;
  logic [7:0] an;
  logic [6:0] a2g;

  seg_scan_arbiter_if ifc ();

  seg_scan_arbiter #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .disp_en (disp_en),
    .req     (ifc),
    .an      (an),
    .a2g     (a2g)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [7:0] an;
    logic [6:0] a2g;
  } pin_exp_t;

  pin_exp_t   pin_q[$];
  int         grant_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         ecnt  = 0;
  logic [6:0] exp_seg [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, req, ecnt, $time);
    end
  endtask

  function automatic int didx(input int e);
    return ((e - 1) >> 2) & 7;
  endfunction

  task automatic push_pin(input int e, input logic en, input logic [6:0] seg);
    pin_exp_t p;
    p.e   = e;
    p.an  = en ? ~(8'h01 << didx(e)) : 8'hFF;
    p.a2g = seg;
    pin_q.push_back(p);
  endtask

  task automatic push_scan(input int e0, input int n);
    for (int e = e0; e < e0 + n; e++) push_pin(e, 1'b1, exp_seg[didx(e)]);
  endtask

  // Pin monitor: edge counter since reset release, compare any entry due at this edge.
  always @(posedge clk) begin
    pin_exp_t pe;
    #1;
    if (rst_n) begin
      ecnt++;
      while (pin_q.size() > 0 && pin_q[0].e <= ecnt) begin
        pe = pin_q.pop_front();
        if (pe.e < ecnt) check("pin_missed", ecnt, pe.e);
        else begin
          check("an", an, pe.an);
          check("a2g", a2g, pe.a2g);
        end
      end
    end
  end

  // Grant monitor: samples the handshake just before the rising edge.
  always @(negedge clk) begin
    int g;
    #4;
    if (rst_n) begin
      if (ifc.req_valid == 2'b11) check("ready_not_both", ifc.req_ready != 2'b11, 1);
      if ((ifc.req_valid & ifc.req_ready) != 2'b00) begin
        if (grant_q.size() == 0) check("grant_unexpected", ifc.req_ready, 0);
        else begin
          g = grant_q.pop_front();
          check("grant", ifc.req_ready, (g == 0) ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // Called at a negedge; holds the request until granted, returns at the negedge after the transfer.
  task automatic xfer(input int i, input logic [31:0] d, input logic [7:0] w,
                      output int waited, output int e_x);
    bit done;
    done   = 1'b0;
    waited = 0;
    e_x    = 0;
    ifc.req_valid[i] = 1'b1;
    if (i == 0) begin ifc.req0_data = d; ifc.req0_wen = w; end
    else        begin ifc.req1_data = d; ifc.req1_wen = w; end
    while (!done && waited < 40) begin
      #4;
      waited++;
      if (ifc.req_ready[i]) begin
        done = 1'b1;
        e_x  = ecnt + 1;
      end
      @(negedge clk);
    end
    ifc.req_valid[i] = 1'b0;
    if (!done) check("xfer_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pin_q.size() != 0 || grant_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", pin_q.size() + grant_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ex, n;
    ifc.req_valid = 2'b00;
    ifc.req0_data = '0;
    ifc.req1_data = '0;
    ifc.req0_wen  = '0;
    ifc.req1_wen  = '0;
    for (int k = 0; k < 8; k++) exp_seg[k] = 7'h7F;

    // Reset takes effect with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_a2g", a2g, 7'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle scan of a blank buffer, concurrently with a tie of wen=0 transfers: grants 0,1,0,1.
    push_scan(1, 32);
    grant_q.push_back(0); grant_q.push_back(1);
    grant_q.push_back(0); grant_q.push_back(1);
    fork
      begin
        int wa, ea;
        xfer(0, 32'h1111_1111, 8'h00, wa, ea);
        xfer(0, 32'h2222_2222, 8'h00, wa, ea);
      end
      begin
        int wb, eb;
        xfer(1, 32'h3333_3333, 8'h00, wb, eb);
        xfer(1, 32'h4444_4444, 8'h00, wb, eb);
      end
    join
    wait_drain();

    // Full-frame write from requester 0, granted in the same cycle.
    grant_q.push_back(0);
    xfer(0, 32'h1234_5678, 8'hFF, w, ex);
    check("r0_same_cycle", w, 1);
    exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    push_scan(ex + 1, 32);
    wait_drain();

    // Requester 1 rewrites digit 0 while digit 0 is on the pins.
    n = 0;
    while ((ecnt % 32) != 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ex = ecnt + 1;
    push_scan(ex, 1);
    exp_seg[0] = 7'h0E;
    push_scan(ex + 1, 32);
    grant_q.push_back(1);
    xfer(1, 32'h9999_999F, 8'h01, w, ex);
    check("r1_same_cycle", w, 1);
    wait_drain();

    // Display disable for 10 edges; scan keeps advancing underneath.
    ex = ecnt;
    disp_en = 1'b0;
    for (int e = ex + 1; e <= ex + 10; e++) push_pin(e, 1'b0, exp_seg[didx(e)]);
    for (int e = ex + 11; e <= ex + 14; e++) push_pin(e, 1'b1, exp_seg[didx(e)]);
    repeat (10) @(negedge clk);
    disp_en = 1'b1;
    wait_drain();

    // Reset mid-dwell while requester 0 is presenting a full-frame write.
    n = 0;
    while ((ecnt % 4) != 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    ifc.req0_data  = 32'hFFFF_FFFF;
    ifc.req0_wen   = 8'hFF;
    ifc.req_valid  = 2'b01;
    #2;
    rst_n = 1'b0;
    ecnt  = 0;
    #1;
    check("rst2_an", an, 8'hFF);
    check("rst2_a2g", a2g, 7'h7F);
    check("rst2_ready", ifc.req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("rst2_hold_a2g", a2g, 7'h7F);
    @(negedge clk);
    ifc.req_valid = 2'b00;
    rst_n = 1'b1;

    // Buffer must be blank and requester 0 must win the first tie.
    for (int k = 0; k < 8; k++) exp_seg[k] = 7'h7F;
    push_scan(1, 32);
    grant_q.push_back(0);
    grant_q.push_back(1);
    fork
      begin
        int wa, ea;
        xfer(0, 32'h5555_5555, 8'h00, wa, ea);
      end
      begin
        int wb, eb;
        xfer(1, 32'h6666_6666, 8'h00, wb, eb);
      end
    join
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
